// File: rtl/sensor_pwr_seq_pkg.sv
// rtl/sensor_pwr_seq_pkg.sv - shared state encoding and helpers for the sensor power sequencer
// Contents: sps_state_e (4-bit state codes exported on state_o), clog2 for the rail index width,
//           tmr_load to turn a step length in cycles into a delay timer load value.
package sensor_pwr_seq_pkg;

    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_PWR_UP    = 4'd1,
        ST_INCK_ON   = 4'd2,
        ST_XCLR_REL  = 4'd3,
        ST_ON        = 4'd4,
        ST_XCLR_ASRT = 4'd5,
        ST_INCK_OFF  = 4'd6,
        ST_PWR_DN    = 4'd7,
        ST_FAULT     = 4'd8
    } sps_state_e;

    // Never returns less than 1 so a single-rail build still gets a real index register.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // The timer signals done at 0, so a step of T cycles loads T-1; 0 and 1 both give a 1-cycle step.
    function automatic int unsigned tmr_load(input int unsigned t);
        return (t <= 1) ? 0 : t - 1;
    endfunction

endpackage

// File: rtl/sensor_pwr_seq_timer.sv
// rtl/sensor_pwr_seq_timer.sv - shared step delay down-counter for the power sequencer
// Ports: clk, reset (async, active-high), i_load/i_value (load request and value),
//        o_value (current count), o_done (count is 0).
module sps_delay_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic [CNT_W-1:0] o_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_value = r_count;
    assign o_done  = (r_count == '0);

endmodule

// File: rtl/sensor_pwr_seq.sv
// rtl/sensor_pwr_seq.sv - SLVS-EC sensor power sequencer: rails, INCK and XCLR in order up, reverse down
// Optional feature: SPS_PGOOD_CHECK_EN (pgood gating of rail steps, pgood timeout and loss -> FAULT).
// Inputs : clk, reset (async, active-high), pwr_req (level), fault_clr (pulse), pgood_i[N_RAILS]
// Outputs: rail_en_o[N_RAILS], inck_en_o, xclr_o, ready_o, busy_o, fault_o, state_o[3:0]
// All outputs are registered and follow the state one cycle later, except that a fault
// clears rail_en_o/inck_en_o/xclr_o on the same edge that enters FAULT.
module sensor_pwr_seq
    import sensor_pwr_seq_pkg::*;
#(
    parameter int N_RAILS = 3,
    parameter int CNT_W   = 24,
    parameter int T_RAIL  = 50000,
    parameter int T_INCK  = 25000,
    parameter int T_XCLR  = 1000,
    parameter int T_PG_TO = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pwr_req,
    input  logic               fault_clr,
    input  logic [N_RAILS-1:0] pgood_i,
    output logic [N_RAILS-1:0] rail_en_o,
    output logic               inck_en_o,
    output logic               xclr_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               fault_o,
    output logic [3:0]         state_o
);

    localparam int               IDX_W    = clog2(N_RAILS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RAILS - 1);
    localparam logic [CNT_W-1:0] LD_RAIL  = CNT_W'(tmr_load(T_RAIL));
    localparam logic [CNT_W-1:0] LD_INCK  = CNT_W'(tmr_load(T_INCK));
    localparam logic [CNT_W-1:0] LD_XCLR  = CNT_W'(tmr_load(T_XCLR));

    sps_state_e         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [N_RAILS-1:0] r_rail_en;
    logic               r_inck_en;
    logic               r_xclr;
    logic               r_ready;
    logic               r_busy;
    logic               r_fault;
    logic [3:0]         r_state_o;

    sps_state_e         w_nstate;
    logic [IDX_W-1:0]   w_nidx;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_done;
    logic               w_fault;
    logic               w_pg_ok;
    logic [N_RAILS-1:0] w_rail_dec;
    logic [CNT_W-1:0]   w_unused_tmr_value;

    sps_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_value (w_unused_tmr_value),
        .o_done  (w_done)
    );

`ifdef SPS_PGOOD_CHECK_EN
    logic [N_RAILS-1:0] r_pg_s1;
    logic [N_RAILS-1:0] r_pg_s2;
    logic [N_RAILS-1:0] r_pg_low_d;
    logic [CNT_W-1:0]   r_pg_cnt;

    // Two-flop synchroniser plus one more stage remembering last cycle's low rails,
    // so a single-cycle pgood dip while powered is tolerated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pg_s1    <= '0;
            r_pg_s2    <= '0;
            r_pg_low_d <= '0;
            r_pg_cnt   <= '0;
        end else begin
            r_pg_s1    <= pgood_i;
            r_pg_s2    <= r_pg_s1;
            r_pg_low_d <= ~r_pg_s2;
            // Restarted on every step entry; only consulted while a rail is ramping in PWR_UP.
            if (w_load) begin
                r_pg_cnt <= CNT_W'(T_PG_TO);
            end else if (r_pg_cnt != '0) begin
                r_pg_cnt <= r_pg_cnt - CNT_W'(1);
            end
        end
    end

    assign w_pg_ok = r_pg_s2[r_idx];

    always_comb begin
        w_fault = 1'b0;
        case (r_state)
            ST_PWR_UP:                      w_fault = (r_pg_cnt == '0) && !w_pg_ok;
            ST_INCK_ON, ST_XCLR_REL, ST_ON: w_fault = |(~r_pg_s2 & r_pg_low_d);
            default:                        w_fault = 1'b0;
        endcase
    end
`else
    // Timer-only sequencing: pgood_i is ignored and FAULT can never be entered.
    logic w_unused_pgood;
    assign w_unused_pgood = ^pgood_i;
    assign w_pg_ok        = 1'b1;
    assign w_fault        = 1'b0;
`endif

    // Next-state, index and timer-load decode; fault overrides everything, then pwr_req, then expiry.
    always_comb begin
        w_nstate   = r_state;
        w_nidx     = r_idx;
        w_load     = 1'b0;
        w_load_val = LD_RAIL;
        if (w_fault) begin
            w_nstate = ST_FAULT;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (pwr_req) begin
                        w_nstate = ST_PWR_UP;
                        w_nidx   = '0;
                        w_load   = 1'b1;
                    end
                end
                ST_PWR_UP: begin
                    if (!pwr_req) begin
                        // Abort: the rail currently ramping is the first one switched off.
                        w_nstate = ST_PWR_DN;
                        w_load   = 1'b1;
                    end else if (w_done && w_pg_ok) begin
                        w_load = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_nstate   = ST_INCK_ON;
                            w_load_val = LD_XCLR;
                        end else begin
                            w_nidx = r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_INCK_ON: begin
                    if (!pwr_req) begin
                        w_nstate   = ST_XCLR_ASRT;
                        w_load     = 1'b1;
                        w_load_val = LD_XCLR;
                    end else if (w_done) begin
                        w_nstate = ST_XCLR_REL;
                    end
                end
                ST_XCLR_REL: begin
                    w_nstate = ST_ON;
                end
                ST_ON: begin
                    if (!pwr_req) begin
                        w_nstate   = ST_XCLR_ASRT;
                        w_load     = 1'b1;
                        w_load_val = LD_XCLR;
                    end
                end
                ST_XCLR_ASRT: begin
                    if (w_done) begin
                        w_nstate   = ST_INCK_OFF;
                        w_load     = 1'b1;
                        w_load_val = LD_INCK;
                    end
                end
                ST_INCK_OFF: begin
                    if (w_done) begin
                        w_nstate = ST_PWR_DN;
                        w_nidx   = LAST_IDX;
                        w_load   = 1'b1;
                    end
                end
                ST_PWR_DN: begin
                    if (w_done) begin
                        if (r_idx == '0) begin
                            w_nstate = ST_OFF;
                        end else begin
                            w_nidx = r_idx - IDX_W'(1);
                            w_load = 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && !pwr_req) begin
                        w_nstate = ST_OFF;
                    end
                end
                default: begin
                    w_nstate = ST_OFF;
                end
            endcase
        end
    end

    // PWR_UP includes the rail being ramped; PWR_DN excludes the rail being dropped.
    always_comb begin
        w_rail_dec = '0;
        for (int i = 0; i < N_RAILS; i++) begin
            case (r_state)
                ST_PWR_UP:   w_rail_dec[i] = (i <= int'(r_idx));
                ST_PWR_DN:   w_rail_dec[i] = (i < int'(r_idx));
                ST_INCK_ON, ST_XCLR_REL, ST_ON, ST_XCLR_ASRT, ST_INCK_OFF:
                             w_rail_dec[i] = 1'b1;
                default:     w_rail_dec[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_OFF;
            r_idx     <= '0;
            r_rail_en <= '0;
            r_inck_en <= 1'b0;
            r_xclr    <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b0;
            r_state_o <= 4'd0;
        end else begin
            r_state   <= w_nstate;
            r_idx     <= w_nidx;
            r_state_o <= r_state;
            r_fault   <= (r_state == ST_FAULT);
            r_busy    <= (r_state == ST_PWR_UP) || (r_state == ST_INCK_ON) ||
                         (r_state == ST_XCLR_REL) || (r_state == ST_XCLR_ASRT) ||
                         (r_state == ST_INCK_OFF) || (r_state == ST_PWR_DN);
            if (w_fault) begin
                // Emergency off: no sequencing, pins drop on the detecting edge.
                r_rail_en <= '0;
                r_inck_en <= 1'b0;
                r_xclr    <= 1'b0;
                r_ready   <= 1'b0;
            end else begin
                r_rail_en <= w_rail_dec;
                r_inck_en <= (r_state == ST_INCK_ON) || (r_state == ST_XCLR_REL) ||
                             (r_state == ST_ON) || (r_state == ST_XCLR_ASRT);
                r_xclr    <= (r_state == ST_XCLR_REL) || (r_state == ST_ON);
                r_ready   <= (r_state == ST_ON);
            end
        end
    end

    assign rail_en_o = r_rail_en;
    assign inck_en_o = r_inck_en;
    assign xclr_o    = r_xclr;
    assign ready_o   = r_ready;
    assign busy_o    = r_busy;
    assign fault_o   = r_fault;
    assign state_o   = r_state_o;

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// tb/tb_sensor_pwr_seq.sv - self-checking bench for sensor_pwr_seq against a timeline reference model
module tb_sensor_pwr_seq;

    localparam int N      = 3;
    localparam int TR     = 4;
    localparam int TI     = 3;
    localparam int TX     = 2;
    localparam int TPG    = 20;
    localparam int UP_LEN = 2 + N*TR + TX;
    localparam int DN_LEN = 1 + TX + TI + N*TR;

`ifdef SPS_PGOOD_CHECK_EN
    localparam logic [N-1:0] PG_IDLE = '1;
`else
    localparam logic [N-1:0] PG_IDLE = '0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         pwr_req;
    logic         fault_clr;
    logic [N-1:0] pgood;
    logic [N-1:0] rail_en;
    logic         inck_en;
    logic         xclr;
    logic         ready;
    logic         busy;
    logic         fault;
    logic [3:0]   state;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    sensor_pwr_seq #(
        .N_RAILS (N),
        .CNT_W   (8),
        .T_RAIL  (TR),
        .T_INCK  (TI),
        .T_XCLR  (TX),
        .T_PG_TO (TPG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pwr_req   (pwr_req),
        .fault_clr (fault_clr),
        .pgood_i   (pgood),
        .rail_en_o (rail_en),
        .inck_en_o (inck_en),
        .xclr_o    (xclr),
        .ready_o   (ready),
        .busy_o    (busy),
        .fault_o   (fault),
        .state_o   (state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {rails, inck, xclr, ready} k cycles after pwr_req rises from OFF.
    function automatic logic [N+2:0] up_vec(input int k);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (k >= 1 + i*TR);
        return {r, k >= 1 + N*TR, k >= 1 + N*TR + TX, k >= UP_LEN};
    endfunction

    // Expected {rails, inck, xclr, ready} k cycles after pwr_req falls in ON.
    function automatic logic [N+2:0] dn_vec(input int k);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (k < 1 + TX + TI + (N-1-i)*TR);
        return {r, k < 1 + TX, k < 1, k < 1};
    endfunction

    // pwr_req rises at 0 and falls (sampled) at cycle e, while rail j=(e-1)/TR is ramping.
    function automatic logic [N+2:0] abort_vec(input int k, input int e);
        logic [N-1:0] r;
        int j;
        if (k <= e) return up_vec(k);
        j = (e - 1) / TR;
        for (int i = 0; i < N; i++) r[i] = (i <= j) && (k < e + 1 + (j - i)*TR);
        return {r, 3'b000};
    endfunction

    task automatic test_reset();
        logic [N+8:0] got;
        reset = 1'b1;
        pwr_req = 1'b0;
        fault_clr = 1'b0;
        pgood = PG_IDLE;
        repeat (3) step();
        got = {rail_en, inck_en, xclr, ready, busy, fault, state};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", got);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_power_up(input int hold);
        logic [N+2:0] got;
        pwr_req = 1'b1;
        for (int k = 0; k <= UP_LEN + hold; k++) begin
            step();
            got = {rail_en, inck_en, xclr, ready};
            checks++;
            if (got !== up_vec(k)) begin
                errors++;
                $display("FAIL power_up k=%0d got %b exp %b", k, got, up_vec(k));
            end
            if (k == 1 + TR) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_up got %b exp 1", busy);
                end
            end
        end
        checks++;
        if ({state, busy} !== {4'd4, 1'b0}) begin
            errors++;
            $display("FAIL on_state got state %0d busy %b exp state 4 busy 0", state, busy);
        end
    endtask

    task automatic test_power_down();
        logic [N+2:0] got;
        pwr_req = 1'b0;
        for (int k = 0; k <= DN_LEN + 1; k++) begin
            step();
            got = {rail_en, inck_en, xclr, ready};
            checks++;
            if (got !== dn_vec(k)) begin
                errors++;
                $display("FAIL power_down k=%0d got %b exp %b", k, got, dn_vec(k));
            end
            if (k == DN_LEN - 1 || k == DN_LEN) begin
                checks++;
                if (state !== ((k == DN_LEN) ? 4'd0 : 4'd7)) begin
                    errors++;
                    $display("FAIL down_state k=%0d got %0d exp %0d", k, state, (k == DN_LEN) ? 0 : 7);
                end
            end
        end
        checks++;
        if ({state, busy} !== 5'd0) begin
            errors++;
            $display("FAIL off_state got state %0d busy %b exp 0 0", state, busy);
        end
    endtask

    task automatic test_abort(input int e);
        logic [N+2:0] got;
        int last;
        last = e + 1 + ((e - 1) / TR + 1) * TR;
        pwr_req = 1'b1;
        for (int k = 0; k <= last; k++) begin
            step();
            got = {rail_en, inck_en, xclr, ready};
            checks++;
            if (got !== abort_vec(k, e)) begin
                errors++;
                $display("FAIL abort_up e=%0d k=%0d got %b exp %b", e, k, got, abort_vec(k, e));
            end
            if (k == e - 1) pwr_req = 1'b0;
        end
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL abort_off e=%0d got %0d exp 0", e, state);
        end
    endtask

    task automatic test_back_to_back(input int r);
        logic [N+2:0] got;
        logic [N+2:0] exp;
        test_power_up($urandom_range(0, 5));
        pwr_req = 1'b0;
        for (int k = 0; k <= DN_LEN + UP_LEN; k++) begin
            step();
            exp = (k <= DN_LEN) ? dn_vec(k) : up_vec(k - DN_LEN);
            got = {rail_en, inck_en, xclr, ready};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reassert_dn r=%0d k=%0d got %b exp %b", r, k, got, exp);
            end
            if (k == r - 1) pwr_req = 1'b1;
        end
        checks++;
        if (state !== 4'd4) begin
            errors++;
            $display("FAIL reassert_on got %0d exp 4", state);
        end
        test_power_down();
    endtask

    task automatic test_async_reset();
        logic [N+8:0] got;
        logic [N+2:0] got_up;
        int c;
        c = $urandom_range(2, N*TR);
        pwr_req = 1'b1;
        for (int k = 0; k <= c; k++) step();
        got_up = {rail_en, inck_en, xclr, ready};
        checks++;
        if (got_up !== up_vec(c)) begin
            errors++;
            $display("FAIL pre_reset c=%0d got %b exp %b", c, got_up, up_vec(c));
        end
        #2;
        reset = 1'b1;
        #1;
        got = {rail_en, inck_en, xclr, ready, busy, fault, state};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0", got);
        end
        pwr_req = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

`ifdef SPS_PGOOD_CHECK_EN
    task automatic test_pgood_timeout();
        logic [N+3:0] got;
        logic [N+3:0] exp;
        logic [N-1:0] r;
        int f;
        f = TR + TPG + 1;
        pgood = PG_IDLE;
        pgood[1] = 1'b0;
        pwr_req = 1'b1;
        for (int k = 0; k <= f + 1; k++) begin
            step();
            for (int i = 0; i < N; i++) r[i] = (i <= 1) && (k >= 1 + i*TR) && (k < f);
            exp = {r, 3'b000, k >= f + 1};
            got = {rail_en, inck_en, xclr, ready, fault};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pg_timeout k=%0d got %b exp %b", k, got, exp);
            end
        end
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        repeat (2) step();
        checks++;
        if ({state, fault} !== {4'd8, 1'b1}) begin
            errors++;
            $display("FAIL fault_sticky got state %0d fault %b exp 8 1", state, fault);
        end
        pwr_req = 1'b0;
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        step();
        checks++;
        if ({state, fault} !== 5'd0) begin
            errors++;
            $display("FAIL fault_clear got state %0d fault %b exp 0 0", state, fault);
        end
        pgood = PG_IDLE;
    endtask

    task automatic test_pgood_glitch();
        int n;
        test_power_up(2);
        pgood[0] = 1'b0;
        step();
        pgood[0] = 1'b1;
        repeat (5) step();
        checks++;
        if ({state, fault} !== {4'd4, 1'b0}) begin
            errors++;
            $display("FAIL pg_glitch_1cyc got state %0d fault %b exp 4 0", state, fault);
        end
        pgood[0] = 1'b0;
        repeat (2) step();
        pgood[0] = 1'b1;
        n = 0;
        while (fault !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if ({fault, state, rail_en} !== {1'b1, 4'd8, {N{1'b0}}}) begin
            errors++;
            $display("FAIL pg_glitch_2cyc got fault %b state %0d rails %b exp 1 8 0", fault, state, rail_en);
        end
        pwr_req = 1'b0;
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        step();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL pg_glitch_clear got %0d exp 0", state);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        pwr_req = 1'b0;
        fault_clr = 1'b0;
        pgood = PG_IDLE;
        test_reset();
        test_power_up(3);
        test_power_down();
        test_abort(TR + 2);
        repeat (4) test_abort($urandom_range(1, N*TR));
        repeat (3) test_back_to_back($urandom_range(1, DN_LEN - 1));
        test_async_reset();
`ifdef SPS_PGOOD_CHECK_EN
        test_pgood_timeout();
        test_pgood_glitch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
